// File: rtl/tb_udp_tx.sv
// tb_udp_tx: self-running UDP/IPv4/Ethernet frame generator.
//
// The block emits one frame per period on a GMII-style byte interface:
// preamble + SFD, Ethernet header, IPv4 header, UDP header, counting payload,
// zero padding up to the 60-byte minimum, and the Ethernet FCS. Idle gaps
// separate the frames.
//
// Ports
//   clk        in   1   single clock, all logic on the rising edge
//   rst        in   1   synchronous active-low reset
//   txd        out  8   transmit byte, 0x00 whenever tx_en is low
//   tx_en      out  1   txd valid: high from the first preamble byte through
//                       the last FCS byte. There is no back-pressure.
//   busy       out  1   high for the same cycles as tx_en
//   frame_cnt  out 16   number of completed frames (wraps)
//
// Output timing: every output is a flop. The byte for a given FSM state and
// counter value appears on txd one cycle after the FSM holds that state/count.
// START_DELAY and GAP_CYCLES are assumed to be at least 1.
module tb_udp_tx #(
    parameter logic [47:0] DST_MAC     = 48'hFFFF_FFFF_FFFF,
    parameter logic [47:0] SRC_MAC     = 48'h000A_3501_0203,
    parameter logic [31:0] SRC_IP      = 32'hC0A8_010A,
    parameter logic [31:0] DST_IP      = 32'hC0A8_0102,
    parameter logic [15:0] SRC_PORT    = 16'h1F90,
    parameter logic [15:0] DST_PORT    = 16'h1F90,
    parameter int          PAYLOAD_LEN = 32,
    parameter int          START_DELAY = 16,
    parameter int          GAP_CYCLES  = 24
) (
    input  logic        clk,
    input  logic        rst,
    output logic [7:0]  txd,
    output logic        tx_en,
    output logic        busy,
    output logic [15:0] frame_cnt
);

    typedef enum logic [3:0] {
        IDLE, PREAMBLE, ETH_HDR, IP_HDR, UDP_HDR, PAYLOAD, PAD, FCS, GAP
    } state_t;

    localparam int          PAD_LEN   = (PAYLOAD_LEN < 18) ? (18 - PAYLOAD_LEN) : 0;
    localparam logic [15:0] TOTAL_LEN = 16'(28 + PAYLOAD_LEN);
    localparam logic [15:0] UDP_LEN   = 16'(8 + PAYLOAD_LEN);
    localparam logic [15:0] IDLE_LAST = 16'(START_DELAY - 1);
    localparam logic [15:0] GAP_LAST  = 16'(GAP_CYCLES - 1);
    localparam logic [15:0] PAY_LAST  = 16'(PAYLOAD_LEN - 1);
    localparam logic [15:0] PAD_LAST  = (PAD_LEN > 0) ? 16'(PAD_LEN - 1) : 16'd0;

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [31:0] crc_q, crc_d;
    logic [15:0] frame_cnt_q, frame_cnt_d;
    logic [7:0]  txd_q, txd_d;
    logic        tx_en_q, tx_en_d;

    logic [31:0] sum0, sum1;
    logic [15:0] sum2, ip_csum;
    logic [111:0] eth_v;
    logic [159:0] ip_v;
    logic [63:0]  udp_v;
    logic [31:0]  crc_fin;
    logic [7:0]   eth_b [16];
    logic [7:0]   ip_b  [32];
    logic [7:0]   udp_b [8];
    logic [7:0]   fcs_b [4];

    // Reflected CRC-32 (0xEDB88320 is 0x04C11DB7 bit-reversed), one byte.
    function automatic logic [31:0] crc32_byte(input logic [31:0] crc,
                                               input logic [7:0]  data);
        logic [31:0] c;
        c = crc ^ {24'h0, data};
        for (int b = 0; b < 8; b++) begin
            c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
        end
        return c;
    endfunction

    // IPv4 header checksum. frame_cnt only changes in GAP, so this value is
    // settled before PREAMBLE and holds for the whole frame.
    always_comb begin
        sum0 = 32'h4500 + {16'h0, TOTAL_LEN} + {16'h0, frame_cnt_q} + 32'h4000
             + 32'h4011 + {16'h0, SRC_IP[31:16]} + {16'h0, SRC_IP[15:0]}
             + {16'h0, DST_IP[31:16]} + {16'h0, DST_IP[15:0]};
        sum1 = {16'h0, sum0[15:0]} + {16'h0, sum0[31:16]};
        sum2 = sum1[15:0] + sum1[31:16];
        ip_csum = ~sum2;
    end

    // Header byte tables, MSB byte first; tables are padded to a power of two.
    always_comb begin
        eth_v   = {DST_MAC, SRC_MAC, 16'h0800};
        ip_v    = {8'h45, 8'h00, TOTAL_LEN, frame_cnt_q, 16'h4000, 8'h40, 8'h11,
                   ip_csum, SRC_IP, DST_IP};
        udp_v   = {SRC_PORT, DST_PORT, UDP_LEN, 16'h0000};
        crc_fin = ~crc_q;
        for (int i = 0; i < 16; i++) eth_b[i] = 8'h00;
        for (int i = 0; i < 32; i++) ip_b[i]  = 8'h00;
        for (int i = 0; i < 14; i++) eth_b[i] = eth_v[111 - 8*i -: 8];
        for (int i = 0; i < 20; i++) ip_b[i]  = ip_v[159 - 8*i -: 8];
        for (int i = 0; i < 8; i++)  udp_b[i] = udp_v[63 - 8*i -: 8];
        // FCS goes out least-significant byte first.
        for (int i = 0; i < 4; i++)  fcs_b[i] = crc_fin[8*i +: 8];
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q + 16'd1;
        crc_d       = crc_q;
        frame_cnt_d = frame_cnt_q;
        txd_d       = 8'h00;
        tx_en_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (cnt_q == IDLE_LAST) state_d = PREAMBLE;
            end
            PREAMBLE: begin
                tx_en_d = 1'b1;
                txd_d   = (cnt_q == 16'd7) ? 8'hD5 : 8'h55;
                crc_d   = 32'hFFFF_FFFF;
                if (cnt_q == 16'd7) state_d = ETH_HDR;
            end
            ETH_HDR: begin
                tx_en_d = 1'b1;
                txd_d   = eth_b[cnt_q[3:0]];
                if (cnt_q == 16'd13) state_d = IP_HDR;
            end
            IP_HDR: begin
                tx_en_d = 1'b1;
                txd_d   = ip_b[cnt_q[4:0]];
                if (cnt_q == 16'd19) state_d = UDP_HDR;
            end
            UDP_HDR: begin
                tx_en_d = 1'b1;
                txd_d   = udp_b[cnt_q[2:0]];
                if (cnt_q == 16'd7) state_d = PAYLOAD;
            end
            PAYLOAD: begin
                tx_en_d = 1'b1;
                txd_d   = frame_cnt_q[7:0] + cnt_q[7:0];
                if (cnt_q == PAY_LAST) state_d = (PAD_LEN > 0) ? PAD : FCS;
            end
            PAD: begin
                tx_en_d = 1'b1;
                if (cnt_q == PAD_LAST) state_d = FCS;
            end
            FCS: begin
                tx_en_d = 1'b1;
                txd_d   = fcs_b[cnt_q[1:0]];
                if (cnt_q == 16'd3) state_d = GAP;
            end
            GAP: begin
                // First gap cycle: the frame just finished on the wire.
                if (cnt_q == 16'd0) frame_cnt_d = frame_cnt_q + 16'd1;
                if (cnt_q == GAP_LAST) state_d = PREAMBLE;
            end
            default: state_d = IDLE;
        endcase
        if (state_q inside {ETH_HDR, IP_HDR, UDP_HDR, PAYLOAD, PAD}) begin
            crc_d = crc32_byte(crc_q, txd_d);
        end
        if (state_d != state_q) cnt_d = 16'd0;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            cnt_q       <= 16'd0;
            crc_q       <= 32'hFFFF_FFFF;
            frame_cnt_q <= 16'd0;
            txd_q       <= 8'h00;
            tx_en_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            crc_q       <= crc_d;
            frame_cnt_q <= frame_cnt_d;
            txd_q       <= txd_d;
            tx_en_q     <= tx_en_d;
        end
    end

    assign txd       = txd_q;
    assign tx_en     = tx_en_q;
    assign busy      = tx_en_q;
    assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_tb_udp_tx.sv
// Bench for tb_udp_tx: a default-parameter instance (start delay, abort by
// reset, two frames, gap) and a PAYLOAD_LEN=4 instance (padding path).
// Expected frames are built from hand-written header bytes and pushed into
// per-instance queues; negedge monitors pop and compare every tx_en byte.
module tb_tb_udp_tx;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, rst4;
    logic [7:0]  txd, txd4;
    logic        tx_en, tx_en4, busy, busy4;
    logic [15:0] frame_cnt, frame_cnt4;

    tb_udp_tx dut (
        .clk(clk), .rst(rst), .txd(txd), .tx_en(tx_en),
        .busy(busy), .frame_cnt(frame_cnt)
    );

    tb_udp_tx #(.PAYLOAD_LEN(4)) dut4 (
        .clk(clk), .rst(rst4), .txd(txd4), .tx_en(tx_en4),
        .busy(busy4), .frame_cnt(frame_cnt4)
    );

    int checks   = 0;
    int failures = 0;
    bit done4    = 1'b0;

    logic [7:0] exp_q[$];
    logic [7:0] exp4_q[$];
    logic [7:0] frm[$];
    logic [7:0] frm4[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    // Bit-serial reflected CRC-32 step.
    function automatic logic [31:0] sw_crc(input logic [31:0] crc_in, input logic [7:0] b);
        logic [31:0] crc;
        logic fb;
        crc = crc_in;
        for (int i = 0; i < 8; i++) begin
            fb  = crc[0] ^ b[i];
            crc = {1'b0, crc[31:1]};
            if (fb) crc = crc ^ 32'hEDB8_8320;
        end
        return crc;
    endfunction

    function automatic logic [31:0] bitrev32(input logic [31:0] v);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) r[i] = v[31 - i];
        return r;
    endfunction

    // Build a frame from literal header bytes and push its first max_bytes
    // bytes into the chosen expected queue.
    task automatic push_frame(input bit to4, input logic [15:0] id, input int plen,
                              input logic [15:0] csum, input int max_bytes);
        logic [7:0]  f[$];
        logic [31:0] crc;
        logic [15:0] tl, ul;
        int          pad;
        tl  = 16'(28 + plen);
        ul  = 16'(8 + plen);
        pad = (plen < 18) ? 18 - plen : 0;
        repeat (7) f.push_back(8'h55);
        f.push_back(8'hD5);
        repeat (6) f.push_back(8'hFF);
        f.push_back(8'h00); f.push_back(8'h0A); f.push_back(8'h35);
        f.push_back(8'h01); f.push_back(8'h02); f.push_back(8'h03);
        f.push_back(8'h08); f.push_back(8'h00);
        f.push_back(8'h45); f.push_back(8'h00); f.push_back(tl[15:8]); f.push_back(tl[7:0]);
        f.push_back(id[15:8]); f.push_back(id[7:0]); f.push_back(8'h40); f.push_back(8'h00);
        f.push_back(8'h40); f.push_back(8'h11); f.push_back(csum[15:8]); f.push_back(csum[7:0]);
        f.push_back(8'hC0); f.push_back(8'hA8); f.push_back(8'h01); f.push_back(8'h0A);
        f.push_back(8'hC0); f.push_back(8'hA8); f.push_back(8'h01); f.push_back(8'h02);
        f.push_back(8'h1F); f.push_back(8'h90); f.push_back(8'h1F); f.push_back(8'h90);
        f.push_back(ul[15:8]); f.push_back(ul[7:0]); f.push_back(8'h00); f.push_back(8'h00);
        for (int i = 0; i < plen; i++) f.push_back(id[7:0] + 8'(i));
        repeat (pad) f.push_back(8'h00);
        crc = 32'hFFFF_FFFF;
        for (int i = 8; i < f.size(); i++) crc = sw_crc(crc, f[i]);
        crc = ~crc;
        f.push_back(crc[7:0]); f.push_back(crc[15:8]);
        f.push_back(crc[23:16]); f.push_back(crc[31:24]);
        for (int i = 0; i < f.size() && i < max_bytes; i++) begin
            if (to4) exp4_q.push_back(f[i]);
            else     exp_q.push_back(f[i]);
        end
    endtask

    // Count negedges until tx_en equals level; n excludes the matching edge.
    task automatic wait_tx(input logic level, input int budget, input string name, output int n);
        n = 0;
        forever begin
            @(negedge clk);
            if (tx_en === level) break;
            n++;
            if (n >= budget) begin
                checks++;
                failures++;
                $display("FAIL %s timeout after %0d cycles, required tx_en=%0b", name, n, level);
                break;
            end
        end
    endtask

    // Monitor, default instance.
    always @(negedge clk) begin
        if (tx_en) begin
            frm.push_back(txd);
            check("busy_hi", {31'h0, busy}, 32'd1);
            if (exp_q.size() == 0) check("unexpected_byte", {24'h0, txd}, 32'h100);
            else check("txd_byte", {24'h0, txd}, {24'h0, exp_q.pop_front()});
        end else begin
            check("idle_out", {23'h0, busy, txd}, 32'h0);
            if (frm.size() == 86) begin
                logic [31:0] r;
                r = 32'hFFFF_FFFF;
                for (int i = 8; i < frm.size(); i++) r = sw_crc(r, frm[i]);
                check("fcs_residue", bitrev32(r), 32'hC704_DD7B);
            end
            frm.delete();
        end
    end

    // Monitor, PAYLOAD_LEN=4 instance.
    always @(negedge clk) begin
        if (tx_en4) begin
            frm4.push_back(txd4);
            if (exp4_q.size() == 0) check("p4_unexpected_byte", {24'h0, txd4}, 32'h100);
            else check("p4_txd_byte", {24'h0, txd4}, {24'h0, exp4_q.pop_front()});
        end else begin
            check("p4_idle_out", {23'h0, busy4, txd4}, 32'h0);
            if (frm4.size() > 0) begin
                logic [31:0] r;
                check("p4_frame_len", frm4.size(), 32'd72);
                r = 32'hFFFF_FFFF;
                for (int i = 8; i < frm4.size(); i++) r = sw_crc(r, frm4[i]);
                check("p4_fcs_residue", bitrev32(r), 32'hC704_DD7B);
            end
            frm4.delete();
        end
    end

    // PAYLOAD_LEN=4: one padded frame (total_len 0x0020, checksum 0xB770).
    initial begin
        int n;
        rst4 = 1'b0;
        repeat (3) @(posedge clk);
        push_frame(1'b1, 16'h0000, 4, 16'hB770, 1000);
        @(negedge clk);
        rst4 = 1'b1;
        n = 0;
        while (tx_en4 !== 1'b1 && n < 200) begin @(negedge clk); n++; end
        check("p4_start_delay", n - 1, 32'd16);
        n = 0;
        while (tx_en4 === 1'b1 && n < 200) begin @(negedge clk); n++; end
        check("p4_tx_cycles", n, 32'd72);
        check("p4_frame_cnt", {16'h0, frame_cnt4}, 32'd1);
        rst4 = 1'b0;
        @(negedge clk);
        check("p4_exp_q_drained", exp4_q.size(), 32'd0);
        done4 = 1'b1;
    end

    // Default instance: reset values, abort at payload byte 10, restart,
    // two complete frames and the gap between them.
    initial begin
        int n;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_tx_en", {31'h0, tx_en}, 32'd0);
        check("rst_busy", {31'h0, busy}, 32'd0);
        check("rst_txd", {24'h0, txd}, 32'd0);
        check("rst_frame_cnt", {16'h0, frame_cnt}, 32'd0);

        // 8 preamble + 14 eth + 20 ip + 8 udp + payload bytes 0..10 = 61.
        push_frame(1'b0, 16'h0000, 32, 16'hB754, 61);
        rst = 1'b1;
        wait_tx(1'b1, 200, "start_wait", n);
        check("start_delay", n, 32'd16);
        n = 1;
        while (n < 61) begin
            @(negedge clk);
            if (tx_en !== 1'b1) break;
            n++;
        end
        check("abort_point_bytes", n, 32'd61);
        rst = 1'b0;
        @(negedge clk);
        check("abort_tx_en", {31'h0, tx_en}, 32'd0);
        check("abort_frame_cnt", {16'h0, frame_cnt}, 32'd0);
        check("abort_exp_q", exp_q.size(), 32'd0);
        @(negedge clk);

        push_frame(1'b0, 16'h0000, 32, 16'hB754, 1000);
        push_frame(1'b0, 16'h0001, 32, 16'hB753, 1000);
        rst = 1'b1;
        wait_tx(1'b1, 200, "restart_wait", n);
        check("restart_delay", n, 32'd16);
        wait_tx(1'b0, 200, "frame0_wait", n);
        check("frame0_len", n + 1, 32'd86);
        check("frame_cnt_after_f0", {16'h0, frame_cnt}, 32'd1);
        wait_tx(1'b1, 200, "gap_wait", n);
        check("gap_len", n + 1, 32'd24);
        wait_tx(1'b0, 200, "frame1_wait", n);
        check("frame1_len", n + 1, 32'd86);
        check("frame_cnt_after_f1", {16'h0, frame_cnt}, 32'd2);
        rst = 1'b0;
        @(negedge clk);
        check("exp_q_drained", exp_q.size(), 32'd0);

        n = 0;
        while (!done4 && n < 1000) begin @(negedge clk); n++; end
        if (!done4) check("p4_done_timeout", 32'd0, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
